// File: rtl/spe_fire_unit.sv
// Spiking PE neuron stage: integrates one partial sum per neuron with its residual
// potential, thresholds it, and writes {potential, spike} back to output memory.
module spe_fire_unit #(
    parameter int SPE_IDX     = 0,
    parameter int NODE_ID     = 0,
    parameter int OMEM_ID     = 11,
    parameter int SUM_WIDTH   = 13,
    parameter int THRESHOLD   = 64,
    parameter int NUM_OUTPUTS = 441
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 psum_valid,
    output logic                 psum_ready,
    input  logic [SUM_WIDTH-1:0] psum_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic [32:0]          rx_pkt,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [32:0]          tx_pkt,
    output logic [1:0]           ts_o,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_RES = 3'd2,
        FIRE     = 3'd3,
        SEND     = 3'd4,
        WAIT_TS  = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam int TARGET = (NUM_OUTPUTS - SPE_IDX + 4) / 5;
    localparam int CNT_W  = $clog2(TARGET + 1);
    localparam logic [CNT_W-1:0]     TARGET_C  = CNT_W'(TARGET);
    localparam logic [3:0]           OMEM_ADDR = 4'(OMEM_ID);
    localparam logic [3:0]           NODE_ADDR = 4'(NODE_ID);
    localparam logic [3:0]           OP_WR     = 4'(2 * SPE_IDX);
    localparam logic [3:0]           OP_RD     = 4'(2 * SPE_IDX + 1);
    localparam logic [3:0]           OP_TS     = 4'd15;
    localparam logic signed [SUM_WIDTH-1:0] TH = SUM_WIDTH'(THRESHOLD);

    // Add two potentials in one extra bit and clamp to the signed SUM_WIDTH range.
    function automatic logic signed [SUM_WIDTH-1:0] sat_add(
        input logic signed [SUM_WIDTH-1:0] a,
        input logic signed [SUM_WIDTH-1:0] b
    );
        logic signed [SUM_WIDTH:0] s;
        s = {a[SUM_WIDTH-1], a} + {b[SUM_WIDTH-1], b};
        if (s[SUM_WIDTH] != s[SUM_WIDTH-1]) begin
            sat_add = s[SUM_WIDTH] ? {1'b1, {(SUM_WIDTH-1){1'b0}}}
                                   : {1'b0, {(SUM_WIDTH-1){1'b1}}};
        end else begin
            sat_add = s[SUM_WIDTH-1:0];
        end
    endfunction

    state_t                        state_r, state_next_s;
    logic [1:0]                    ts_r;
    logic [CNT_W-1:0]              cnt_r;
    logic signed [SUM_WIDTH-1:0]   psum_r, res_r;
    logic                          pending_r;
    logic                          tx_valid_r, psum_ready_r, rx_ready_r, done_r, err_r;
    logic [32:0]                   tx_pkt_r;

    logic                          psum_acc_s, rx_acc_s, tx_acc_s, last_s, rx_ts_s, ts2_s;
    logic signed [SUM_WIDTH-1:0]   v_s, pot_s;
    logic                          spike_s;
    logic                          unused_s;

    assign psum_acc_s = psum_valid && psum_ready_r;
    assign rx_acc_s   = rx_valid && rx_ready_r;
    assign tx_acc_s   = tx_valid_r && tx_ready;
    assign last_s     = ((cnt_r + CNT_W'(1)) == TARGET_C);
    assign rx_ts_s    = (rx_pkt[28:25] == OP_TS);
    assign ts2_s      = (ts_r == 2'd2);

    // Routing on dest is the router's job; the reply address and high data bits are ignored.
    assign unused_s = ^{rx_pkt[32:29] ^ NODE_ADDR, rx_pkt[24:SUM_WIDTH]};

    // Integrate, threshold and reset the potential of the latched neuron.
    always_comb begin
        v_s     = sat_add(psum_r, res_r);
        spike_s = (v_s >= TH);
        if (spike_s) begin
            pot_s = v_s - TH;
        end else begin
            pot_s = v_s;
        end
    end

    // Next-state logic of the neuron sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (psum_acc_s) begin
                    state_next_s = ts2_s ? REQ : FIRE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (tx_acc_s) begin
                    state_next_s = WAIT_RES;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT_RES: begin
                if (rx_acc_s && !rx_ts_s) begin
                    state_next_s = FIRE;
                end else begin
                    state_next_s = WAIT_RES;
                end
            end
            FIRE: state_next_s = SEND;
            SEND: begin
                if (!tx_acc_s) begin
                    state_next_s = SEND;
                end else if (!last_s) begin
                    state_next_s = IDLE;
                end else if (ts2_s) begin
                    state_next_s = DONE;
                end else if (pending_r) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_TS;
                end
            end
            WAIT_TS: begin
                if (rx_acc_s && rx_ts_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_TS;
                end
            end
            DONE:    state_next_s = DONE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Handshake outputs; readies follow the next state so a sum or packet is never taken twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_ready_r <= 1'b0;
            rx_ready_r   <= 1'b0;
            tx_valid_r   <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            psum_ready_r <= (state_next_s == IDLE);
            rx_ready_r   <= (state_next_s == WAIT_RES) || (state_next_s == WAIT_TS);
            done_r       <= (state_next_s == DONE);
            if (tx_acc_s) begin
                tx_valid_r <= 1'b0;
            end else begin
                tx_valid_r <= (state_r == REQ) || (state_r == SEND);
            end
        end
    end

    // Neuron datapath, packet register, timestep and neuron counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r      <= 2'd1;
            cnt_r     <= '0;
            psum_r    <= '0;
            res_r     <= '0;
            pending_r <= 1'b0;
            tx_pkt_r  <= 33'd0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (psum_acc_s) begin
                        psum_r <= psum_data;
                        res_r  <= '0;
                        if (ts2_s) begin
                            tx_pkt_r <= {OMEM_ADDR, OP_RD, 25'd0};
                        end
                    end
                end
                WAIT_RES: begin
                    if (rx_acc_s) begin
                        if (rx_ts_s) begin
                            pending_r <= 1'b1;
                        end else begin
                            res_r <= rx_pkt[SUM_WIDTH-1:0];
                        end
                    end
                end
                FIRE: begin
                    tx_pkt_r <= {OMEM_ADDR, OP_WR, {(24-SUM_WIDTH){1'b0}}, pot_s, spike_s};
                end
                SEND: begin
                    if (tx_acc_s) begin
                        cnt_r <= last_s ? '0 : cnt_r + CNT_W'(1);
                        // A timestep switch seen early is applied as soon as ts1 completes.
                        if (last_s && !ts2_s) begin
                            pending_r <= 1'b0;
                            if (pending_r) begin
                                ts_r <= 2'd2;
                            end
                        end
                    end
                end
                WAIT_TS: begin
                    if (rx_acc_s) begin
                        if (rx_ts_s) begin
                            ts_r  <= 2'd2;
                            cnt_r <= '0;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign psum_ready = psum_ready_r;
    assign rx_ready   = rx_ready_r;
    assign tx_valid   = tx_valid_r;
    assign tx_pkt     = tx_pkt_r;
    assign ts_o       = ts_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule
